// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared definitions for the serial adder: FSM state encoding
//                and the digit-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : digit_adder
//  Description : Combinational DIGIT-bit ripple-carry adder built from
//                full_adder cells.
//  Ports       : x, y  - DIGIT-bit addends
//                ci    - carry in
//                s     - DIGIT-bit sum
//                co    - carry out of the top bit
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] carry;

    assign carry[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (carry[i]),
            .s    (s[i]),
            .cout (carry[i+1])
        );
    end

    assign co = carry[DIGIT];

endmodule
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit full adder.
//  Ports       : a, b, cin  - addend bits and carry in
//                s, cout    - sum bit and carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Multi-cycle adder computing a + b + cin, DIGIT bits per
//                clock, LSB digit first, with a registered inter-digit carry.
//  Ports       : clk, rst_n        - clock, asynchronous active-low reset
//                start             - request, accepted while ready=1
//                a, b, cin         - operands, sampled on the accept edge
//                ready, busy, done - IDLE / BUSY / one-cycle DONE indicators
//                sum, cout         - result, held until the next accept
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    if ((WIDTH < 1) || (WIDTH % DIGIT != 0)) begin : g_param_check
        $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DIGIT-1:0]   dig_s;
    logic               dig_co;
    // New digit enters at the top; dropping the low DIGIT bits of this
    // concatenation is the right-shift of the sum register.
    logic [WIDTH+DIGIT-1:0] sum_cat;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x  (a_q[DIGIT-1:0]),
        .y  (b_q[DIGIT-1:0]),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_co)
    );

    assign sum_cat = {dig_s, sum_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];
                carry_d = dig_co;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cout_d  = dig_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q == ST_BUSY);
    assign done  = (state_q == ST_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder. Three instances
//                (8/1, 8/4, 4/2); expected {cout,sum} values are queued at
//                issue time and popped by a monitor on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       st0 = 0, ci0 = 0, rdy0, bsy0, dn0, co0;
    logic [7:0] a0 = 0, b0 = 0, s0;
    logic       st1 = 0, ci1 = 0, rdy1, bsy1, dn1, co1;
    logic [7:0] a1 = 0, b1 = 0, s1;
    logic       st2 = 0, ci2 = 0, rdy2, bsy2, dn2, co2;
    logic [3:0] a2 = 0, b2 = 0, s2;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .a(a0), .b(b0), .cin(ci0),
        .ready(rdy0), .busy(bsy0), .done(dn0), .sum(s0), .cout(co0));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(ci1),
        .ready(rdy1), .busy(bsy1), .done(dn1), .sum(s1), .cout(co1));
    serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2), .cin(ci2),
        .ready(rdy2), .busy(bsy2), .done(dn2), .sum(s2), .cout(co2));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int dn2_cnt = 0;
    int last2 = -1;
    bit sweep_on = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Reference: full-precision integer sum; its top bit is the carry out.
    function automatic logic [8:0] ref_add(input int w, input logic [7:0] a, input logic [7:0] b,
                                           input logic c);
        int t;
        t = int'(a) + int'(b) + int'(c);
        return 9'(t % (1 << (w + 1)));
    endfunction

    function automatic logic rdy(input int k);
        return (k == 0) ? rdy0 : (k == 1) ? rdy1 : rdy2;
    endfunction
    function automatic logic bsy(input int k);
        return (k == 0) ? bsy0 : (k == 1) ? bsy1 : bsy2;
    endfunction
    function automatic logic dn(input int k);
        return (k == 0) ? dn0 : (k == 1) ? dn1 : dn2;
    endfunction

    task automatic drive(input int k, input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic c);
        case (k)
            0:       begin st0 = s; a0 = a; b0 = b; ci0 = c; end
            1:       begin st1 = s; a1 = a; b1 = b; ci1 = c; end
            default: begin st2 = s; a2 = a[3:0]; b2 = b[3:0]; ci2 = c; end
        endcase
    endtask

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy(k) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(k)) flag($sformatf("dut%0d ready timeout: ready=0, required 1", k));
    endtask

    // Issues one add and returns 1 ns after the accept edge.
    task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b, input logic c);
        wait_ready(k);
        drive(k, 1'b1, a, b, c);
        case (k)
            0:       q0.push_back(ref_add(8, a, b, c));
            1:       q1.push_back(ref_add(8, a, b, c));
            default: q2.push_back(ref_add(4, {4'd0, a[3:0]}, {4'd0, b[3:0]}, c));
        endcase
        @(posedge clk);
        #1;
        drive(k, 1'b0, a, b, c);
    endtask

    task automatic check_timing(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("dut%0d busy in cycle %0d", k, i + 1), 32'(bsy(k)), 32'd1);
            chk($sformatf("dut%0d done low in cycle %0d", k, i + 1), 32'(dn(k)), 32'd0);
            @(posedge clk);
            #1;
        end
        chk($sformatf("dut%0d done pulse", k), 32'(dn(k)), 32'd1);
        chk($sformatf("dut%0d busy after op", k), 32'(bsy(k)), 32'd0);
        @(posedge clk);
        #1;
        chk($sformatf("dut%0d done one cycle", k), 32'(dn(k)), 32'd0);
        chk($sformatf("dut%0d ready after done", k), 32'(rdy(k)), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (dn0) begin
            if (q0.size() == 0) flag("dut0 unexpected done pulse: done=1, required 0");
            else chk("dut0 {cout,sum}", 32'({co0, s0}), 32'(q0.pop_front()));
        end
        if (dn1) begin
            if (q1.size() == 0) flag("dut1 unexpected done pulse: done=1, required 0");
            else chk("dut1 {cout,sum}", 32'({co1, s1}), 32'(q1.pop_front()));
        end
        if (dn2) begin
            dn2_cnt++;
            if (q2.size() == 0) flag("dut2 unexpected done pulse: done=1, required 0");
            else chk("dut2 {cout,sum}", 32'({co2, s2}), 32'(q2.pop_front()));
            if (sweep_on && last2 >= 0) chk("dut2 done spacing", 32'(cyc - last2), 32'd4);
            last2 = cyc;
        end
    end

    initial begin
        #1;
        chk("reset ready", 32'(rdy0), 32'd1);
        chk("reset busy", 32'(bsy0), 32'd0);
        chk("reset done", 32'(dn0), 32'd0);
        chk("reset sum", 32'(s0), 32'd0);
        chk("reset cout", 32'(co0), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // FF + 01: wrap to zero with carry, held through idle.
        issue(0, 8'hFF, 8'h01, 1'b0);
        check_timing(0, 8);
        idle_cycles(5);
        chk("dut0 held sum", 32'(s0), 32'h00);
        chk("dut0 held cout", 32'(co0), 32'd1);

        // 5A + 33 + 1, with operand changes and a stray start while busy.
        issue(0, 8'h5A, 8'h33, 1'b1);
        drive(0, 1'b0, 8'h00, 8'hFF, 1'b0);
        idle_cycles(2);
        drive(0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        idle_cycles(1);
        drive(0, 1'b0, 8'hFF, 8'hFF, 1'b1);
        idle_cycles(20);
        chk("dut0 sum after ignored start", 32'(s0), 32'h8E);
        chk("dut0 cout after ignored start", 32'(co0), 32'd0);

        // DIGIT=4: two busy cycles.
        issue(1, 8'hC8, 8'h64, 1'b0);
        check_timing(1, 2);
        chk("dut1 sum", 32'(s1), 32'h2C);

        // Abort mid-operation with an asynchronous reset pulse.
        issue(0, 8'hAA, 8'h55, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #0.5;
        chk("abort ready", 32'(rdy0), 32'd1);
        chk("abort busy", 32'(bsy0), 32'd0);
        chk("abort sum", 32'(s0), 32'd0);
        chk("abort cout", 32'(co0), 32'd0);
        #0.5;
        rst_n = 1'b1;
        q0.delete();
        idle_cycles(12);
        issue(0, 8'h01, 8'h01, 1'b0);
        idle_cycles(12);
        chk("dut0 sum after abort", 32'(s0), 32'h02);

        // Randomized operands on both 8-bit instances.
        for (int i = 0; i < 16; i++) begin
            issue(0, 8'($urandom), 8'($urandom), 1'($urandom));
            issue(1, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        idle_cycles(15);

        // Exhaustive sweep with start held high on the 4-bit instance.
        sweep_on = 1;
        for (int idx = 0; idx < 512; idx++) begin
            wait_ready(2);
            drive(2, 1'b1, {4'd0, 4'(idx)}, {4'd0, 4'(idx >> 4)}, 1'(idx >> 8));
            q2.push_back(ref_add(4, {4'd0, 4'(idx)}, {4'd0, 4'(idx >> 4)}, 1'(idx >> 8)));
            @(posedge clk);
        end
        #1;
        drive(2, 1'b0, 8'd0, 8'd0, 1'b0);
        begin
            int n;
            n = 0;
            while (dn2_cnt < 512 && n < 100) begin
                @(posedge clk);
                n++;
            end
        end
        idle_cycles(5);
        chk("dut2 done count", 32'(dn2_cnt), 32'd512);
        chk("dut0 queue drained", 32'(q0.size()), 32'd0);
        chk("dut1 queue drained", 32'(q1.size()), 32'd0);
        chk("dut2 queue drained", 32'(q2.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        flag("watchdog expired: simulation still running, required finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
